// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX pipeline register / hazard logic and the multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = muldiv_pkg::MD_WIDTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata, flush,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata, flush,
    output busy, stall, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers; works on operand magnitudes
// and applies sign correction in a final FIX cycle.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_muldiv_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic               is_div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic               dbz_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   orig_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg, div_by_zero_reg;

  // Operand decode for the accepting edge
  md_op_e           op_in;
  logic             in_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_in     = md_op_e'(bus.op);
    in_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    a_neg     = in_signed & bus.rs_val[WIDTH-1];
    b_neg     = in_signed & bus.rt_val[WIDTH-1];
    a_mag     = a_neg ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
    b_mag     = b_neg ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;
  end

  // One radix-2 step. For divide, acc holds {partial remainder, dividend/quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_reg};
    div_sub   = div_shift[WIDTH-1:0] - mcand_reg;
    div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
    quo_fix  = neg_res_reg ? (~acc_reg[WIDTH-1:0] + WIDTH'(1)) : acc_reg[WIDTH-1:0];
    rem_fix  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + WIDTH'(1))
                           : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start && !bus.flush) state_next = RUN;
      RUN:     if (bus.flush) state_next = IDLE;
               else if (count_reg == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg       <= '0;
      is_div_reg      <= 1'b0;
      neg_res_reg     <= 1'b0;
      neg_rem_reg     <= 1'b0;
      dbz_reg         <= 1'b0;
      mcand_reg       <= '0;
      orig_reg        <= '0;
      acc_reg         <= '0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      done_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
      if (bus.hi_we) hi_reg <= bus.wdata;
      if (bus.lo_we) lo_reg <= bus.wdata;

      case (state_reg)
        IDLE: if (bus.start && !bus.flush) begin
          count_reg   <= '0;
          is_div_reg  <= in_div;
          neg_res_reg <= a_neg ^ b_neg;
          neg_rem_reg <= a_neg;
          dbz_reg     <= in_div && (bus.rt_val == '0);
          orig_reg    <= bus.rs_val;
          mcand_reg   <= in_div ? b_mag : a_mag;
          acc_reg     <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
        end
        RUN: if (!bus.flush) begin
          acc_reg   <= is_div_reg ? div_next : mul_next;
          count_reg <= count_reg + CW'(1);
        end
        // Placed after the MTHI/MTLO writes so a coinciding FIX takes priority
        FIX: if (!bus.flush) begin
          if (is_div_reg) begin
            hi_reg <= dbz_reg ? orig_reg : rem_fix;
            lo_reg <= dbz_reg ? '1 : quo_fix;
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
          done_reg        <= 1'b1;
          div_by_zero_reg <= dbz_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.stall       = bus.start | bus.busy;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = div_by_zero_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: stimulus pushes expected HI/LO into a queue, a monitor
// thread pops and compares on every done pulse.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(W)) bus();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("hi", 64'(bus.hi), 64'(e.hi));
          check("lo", 64'(bus.lo), 64'(e.lo));
          check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        end
      end else if (bus.div_by_zero !== 1'b0) begin
        check("dbz_without_done", 64'(bus.div_by_zero), 64'(0));
      end
    end
  endtask

  task automatic run_op(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                        input bit clash);
    int idx;
    int stalls;
    bit got;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
    idx = 0; stalls = 0; got = 1'b0;
    while (idx < 100) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (clash && (idx + 1 == W + 1)) begin
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
      end else begin
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      idx++;
    end
    check("done_seen", 64'(got), 64'(1));
    check("latency", 64'(idx), 64'(W + 2));
    check("stall_cycles", 64'(stalls), 64'(W + 2));
    check("busy_in_done", 64'(bus.busy), 64'(0));
    last_hi = ehi;
    last_lo = elo;
    $display("op=%s a=%h b=%h -> hi=%h lo=%h dbz=%0d",
             op.name(), a, b, bus.hi, bus.lo, bus.div_by_zero);
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_stall", 64'(bus.stall), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    $display("reset: hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
    rst_n = 1'b1;

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op(MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op(MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    run_op(MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
    // MTHI/MTLO on the FIX edge loses to the result
    run_op(MD_MULTU, 32'h00001000, 32'h00000003, 32'h00000000, 32'h00003000, 1'b0, 1'b1);

    // Second start while busy is ignored; flush squashes without touching HI/LO
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MD_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 4);
      bus.flush = (k == 9);
      if (k == 4)  check("busy_in_run", 64'(bus.busy), 64'(1));
      if (k == 10) check("flush_idle", 64'(bus.busy), 64'(0));
      if (k == 11) check("flush_stays_idle", 64'(bus.busy), 64'(0));
    end
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi_kept", 64'(bus.hi), 64'(last_hi));
    check("flush_lo_kept", 64'(bus.lo), 64'(last_lo));
    $display("flush: busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    run_op(MD_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0, 1'b0);

    // MTLO then MTHI in IDLE
    @(posedge clk); #1;
    bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'(32'h12345678));
    check("mtlo_hi_kept", 64'(bus.hi), 64'(last_hi));
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'(32'hCAFEF00D));
    $display("mt: hi=%h lo=%h", bus.hi, bus.lo);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MD_MULTU; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'hFFFFFFFF;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_hi", 64'(bus.hi), 64'(0));
    check("arst_lo", 64'(bus.lo), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    $display("mid-run reset: busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("arst_still_idle", 64'(bus.busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
